lab4_rsd_btn_edge: RTL and testbench

- Sequential front end that conditions one raw push-button/switch input for the lab combinational stages.
- Flow: synchronise -> debounce -> clean level `stable`.
- Rising/falling edge pulses use the NOT-A-AND-B form: rise = ~stable_d & stable; fall = stable_d & ~stable.
- Counts debounced rising edges in a wrapping counter for display/LED logic downstream.

---
 rtl/lab4_rsd_pkg.sv | 21 ++
 rtl/lab4_rsd_sync.sv | 24 ++
 rtl/lab4_rsd_btn_edge.sv | 146 ++++++++++++++
 tb/tb_lab4_rsd_btn_edge.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/lab4_rsd_pkg.sv
// Shared types and default sizes for the button-edge front end.
// The enum is the debounce FSM's state encoding; the defaults are also used by benches.
package lab4_rsd_pkg;

  typedef enum logic [1:0] {
    S_LOW   = 2'b00,
    S_CHK_H = 2'b01,
    S_HIGH  = 2'b10,
    S_CHK_L = 2'b11
  } btn_state_t;

  localparam int unsigned SYNC_STAGES_DEF     = 2;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
  localparam int unsigned CNT_W_DEF           = 8;

  // True while a candidate level change is being qualified.
  function automatic logic is_chk_state(input btn_state_t s);
    return (s == S_CHK_H) || (s == S_CHK_L);
  endfunction

endpackage

// File: rtl/lab4_rsd_sync.sv
// N-stage flop chain that brings an asynchronous level into the clk domain.
// The output is the last stage only; earlier stages may be metastable.
module lab4_rsd_sync #(
  parameter int unsigned N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[N-2:0], d};
    end
  end

  assign q = sync_q[N-1];

endmodule

// File: rtl/lab4_rsd_btn_edge.sv
// Button front end: synchronise, debounce, edge-detect and count rising edges.
//   state   | meaning
//   S_LOW   | accepted level 0, idle
//   S_CHK_H | btn_s high, counting consecutive high samples
//   S_HIGH  | accepted level 1, idle
//   S_CHK_L | btn_s low, counting consecutive low samples
module lab4_rsd_btn_edge
  import lab4_rsd_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_in,
  input  logic             clr,
  output logic             stable,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] count,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DW-1:0] DCNT_ONE  = DW'(1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic             btn_s;
  btn_state_t       state_q, state_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic             stable_q, stable_d;
  logic             stable_dly_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  lab4_rsd_sync #(
    .N (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_in),
    .q     (btn_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_LOW;
      dcnt_q       <= '0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dcnt_q       <= dcnt_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
    end
  end

  // The first differing sample counts as one; acceptance on the DEBOUNCE_CYCLES-th.
  always_comb begin
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    stable_d = stable_q;
    unique case (state_q)
      S_LOW: begin
        if (btn_s) begin
          state_d = S_CHK_H;
          dcnt_d  = DCNT_ONE;
        end
      end
      S_CHK_H: begin
        if (!btn_s) begin
          state_d = S_LOW;
          dcnt_d  = '0;
        end else if (dcnt_q == DCNT_LAST) begin
          state_d  = S_HIGH;
          dcnt_d   = '0;
          stable_d = 1'b1;
        end else begin
          dcnt_d = dcnt_q + DCNT_ONE;
        end
      end
      S_HIGH: begin
        if (!btn_s) begin
          state_d = S_CHK_L;
          dcnt_d  = DCNT_ONE;
        end
      end
      S_CHK_L: begin
        if (btn_s) begin
          state_d = S_HIGH;
          dcnt_d  = '0;
        end else if (dcnt_q == DCNT_LAST) begin
          state_d  = S_LOW;
          dcnt_d   = '0;
          stable_d = 1'b0;
        end else begin
          dcnt_d = dcnt_q + DCNT_ONE;
        end
      end
      default: begin
        state_d = S_LOW;
        dcnt_d  = '0;
      end
    endcase
  end

  always_comb begin
    busy = is_chk_state(state_q);
  end

  // Pulses come only from registers so downstream sees no combinational glitches.
  assign rise_pulse = ~stable_dly_q &  stable_q;
  assign fall_pulse =  stable_dly_q & ~stable_q;

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (rise_pulse) begin
      count_d = count_q + CNT_W'(1);
      if (&count_q) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign stable = stable_q;
  assign count  = count_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_lab4_rsd_btn_edge.sv
// Bench for lab4_rsd_btn_edge: a default-width instance and a 2-bit-counter instance
// share one stimulus stream and are checked against a sliding-window model.
module tb_lab4_rsd_btn_edge;
  import lab4_rsd_pkg::*;

  localparam int SYNC = SYNC_STAGES_DEF;
  localparam int DC   = DEBOUNCE_CYCLES_DEF;
  localparam int CW   = CNT_W_DEF;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_in;
  logic clr;

  logic          stable_a, rise_a, fall_a, ovf_a, busy_a;
  logic [CW-1:0] count_a;
  logic          stable_b, rise_b, fall_b, ovf_b, busy_b;
  logic [1:0]    count_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lab4_rsd_btn_edge #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DC), .CNT_W(CW)) dut_a (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .clr(clr),
    .stable(stable_a), .rise_pulse(rise_a), .fall_pulse(fall_a),
    .count(count_a), .ovf(ovf_a), .busy(busy_a)
  );

  lab4_rsd_btn_edge #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DC), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .clr(clr),
    .stable(stable_b), .rise_pulse(rise_b), .fall_pulse(fall_b),
    .count(count_b), .ovf(ovf_b), .busy(busy_b)
  );

  // Model: the level flips once the last DC synchronised samples all disagree with it.
  typedef struct packed {
    logic            stable;
    logic            prev;
    logic            busy;
    logic [CW-1:0]   cnt8;
    logic            ovf8;
    logic [1:0]      cnt2;
    logic            ovf2;
    logic [SYNC-1:0] pipe;
    logic [DC-1:0]   hist;
  } m_t;

  m_t m;

  function automatic m_t step_model(input m_t s, input logic b, input logic c);
    m_t   n    = s;
    logic rise = s.stable & ~s.prev;
    logic samp = s.pipe[SYNC-1];
    if (c) begin
      n.cnt8 = '0; n.ovf8 = 1'b0;
      n.cnt2 = '0; n.ovf2 = 1'b0;
    end else if (rise) begin
      if (int'(s.cnt8) == (1 << CW) - 1) n.ovf8 = 1'b1;
      if (int'(s.cnt2) == 3) n.ovf2 = 1'b1;
      n.cnt8 = CW'((int'(s.cnt8) + 1) % (1 << CW));
      n.cnt2 = 2'((int'(s.cnt2) + 1) % 4);
    end
    n.prev = s.stable;
    n.pipe = {s.pipe[SYNC-2:0], b};
    n.hist = {s.hist[DC-2:0], samp};
    if (n.hist == {DC{~s.stable}}) n.stable = ~s.stable;
    n.busy = (samp != n.stable);
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= step_model(m, btn_in, clr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("a_stable", 32'(stable_a), 32'(m.stable));
    chk("a_rise",   32'(rise_a),   32'(m.stable & ~m.prev));
    chk("a_fall",   32'(fall_a),   32'(~m.stable & m.prev));
    chk("a_busy",   32'(busy_a),   32'(m.busy));
    chk("a_count",  32'(count_a),  32'(m.cnt8));
    chk("a_ovf",    32'(ovf_a),    32'(m.ovf8));
    chk("b_stable", 32'(stable_b), 32'(m.stable));
    chk("b_rise",   32'(rise_b),   32'(m.stable & ~m.prev));
    chk("b_fall",   32'(fall_b),   32'(~m.stable & m.prev));
    chk("b_busy",   32'(busy_b),   32'(m.busy));
    chk("b_count",  32'(count_b),  32'(m.cnt2));
    chk("b_ovf",    32'(ovf_b),    32'(m.ovf2));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      compare_all();
    end
  endtask

  task automatic press();
    btn_in = 1'b1;
    step(8);
    btn_in = 1'b0;
    step(8);
  endtask

  initial begin
    rst_n  = 1'b0;
    btn_in = 1'b1;
    clr    = 1'b0;

    // Reset held with the button already pressed.
    step(1);
    chk("rst_stable", 32'(stable_a), 0);
    chk("rst_rise",   32'(rise_a),   0);
    chk("rst_busy",   32'(busy_a),   0);
    chk("rst_count",  32'(count_a),  0);
    chk("rst_ovf",    32'(ovf_a),    0);
    step(1);
    rst_n = 1'b1;
    step(5);
    chk("lat_pre_stable", 32'(stable_a), 0);
    chk("lat_pre_busy",   32'(busy_a),   1);
    step(1);
    chk("lat_stable", 32'(stable_a), 1);
    chk("lat_rise",   32'(rise_a),   1);
    step(1);
    chk("lat_rise_end", 32'(rise_a),  0);
    chk("lat_count",    32'(count_a), 1);

    // Clean release and press/release.
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("clr_count", 32'(count_a), 0);
    btn_in = 1'b0;
    step(5);
    chk("rel_fall_pre", 32'(fall_a), 0);
    step(1);
    chk("rel_fall",   32'(fall_a),   1);
    chk("rel_stable", 32'(stable_a), 0);
    step(1);
    chk("rel_fall_end", 32'(fall_a), 0);
    step(3);
    btn_in = 1'b1;
    step(5);
    chk("press_rise_pre", 32'(rise_a), 0);
    step(1);
    chk("press_rise", 32'(rise_a), 1);
    step(4);
    btn_in = 1'b0;
    step(6);
    chk("press_fall", 32'(fall_a), 1);
    step(1);
    chk("press_fall_end", 32'(fall_a),  0);
    chk("press_count",    32'(count_a), 1);

    // Glitches of 2 and DC-1 cycles.
    btn_in = 1'b1;
    step(2);
    btn_in = 1'b0;
    step(1);
    chk("glitch_busy3", 32'(busy_a), 1);
    step(1);
    chk("glitch_busy4", 32'(busy_a), 1);
    step(1);
    chk("glitch_busy5",   32'(busy_a),   0);
    chk("glitch_stable",  32'(stable_a), 0);
    step(5);
    btn_in = 1'b1;
    step(DC - 1);
    btn_in = 1'b0;
    step(8);
    chk("glitch3_stable", 32'(stable_a), 0);
    chk("glitch_count",   32'(count_a),  1);

    // Wrap on the 2-bit instance.
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      press();
      chk("wrap_count", 32'(count_b), 32'(i % 4));
      chk("wrap_ovf",   32'(ovf_b),   32'(i >= 4));
    end
    chk("five_count", 32'(count_a), 5);

    // clr in the same cycle as a rise pulse.
    btn_in = 1'b1;
    step(6);
    chk("coll_rise", 32'(rise_a), 1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("coll_count_a", 32'(count_a), 0);
    chk("coll_ovf_a",   32'(ovf_a),   0);
    chk("coll_count_b", 32'(count_b), 0);
    chk("coll_ovf_b",   32'(ovf_b),   0);
    step(1);
    btn_in = 1'b0;
    step(8);
    press();
    chk("after_coll_count", 32'(count_a), 1);

    // Async reset while qualifying a release.
    btn_in = 1'b1;
    step(8);
    chk("pre_rst_count", 32'(count_a), 2);
    btn_in = 1'b0;
    step(3);
    chk("mid_busy",   32'(busy_a),   1);
    chk("mid_stable", 32'(stable_a), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_stable", 32'(stable_a), 0);
    chk("arst_busy",   32'(busy_a),   0);
    chk("arst_count",  32'(count_a),  0);
    chk("arst_fall",   32'(fall_a),   0);
    step(2);
    rst_n = 1'b1;
    step(12);
    chk("post_rst_stable", 32'(stable_a), 0);
    chk("post_rst_count",  32'(count_a),  0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
